// File: rtl/data_memory_responder.sv
// Stage-2 data memory responder: synchronous RAM, MMIO bank (LED, timer, status, cycles), unmapped hole.
// Define DMEM_CYCLE_COUNTER_EN to build the free-running cycle counter read at IO_BASE+3.
module data_memory_responder #(
    parameter int ADDR_SIZE     = 18,
    parameter int WORD_SIZE     = 18,
    parameter int RAM_ADDR_BITS = 12,
    parameter logic [ADDR_SIZE-1:0] IO_BASE = 18'h3FF00
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] memory_addr,
    input  logic                 memory_write_enable,
    input  logic [WORD_SIZE-1:0] memory_in,
    input  logic                 waiting_global,
    output logic [WORD_SIZE-1:0] memory_out,
    output logic [WORD_SIZE-1:0] led_out,
    output logic                 timer_expired,
    output logic                 access_fault
);
    localparam int RAM_DEPTH = 2 ** RAM_ADDR_BITS;
    localparam logic [ADDR_SIZE-1:0] IO_LAST = IO_BASE + ADDR_SIZE'(3);
    localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);

    logic [WORD_SIZE-1:0] ram_q [RAM_DEPTH];
    logic [WORD_SIZE-1:0] ram_rd_q;
    logic [WORD_SIZE-1:0] io_rd_q, io_rd_d;
    logic [WORD_SIZE-1:0] led_q, led_d;
    logic [WORD_SIZE-1:0] count_q, count_d;
    logic [WORD_SIZE-1:0] cyc_rd;
    logic                 rd_ram_q;
    logic                 done_q, done_d;
    logic                 expired_q, expire_d;
    logic                 fault_q;
    logic                 active, is_ram, is_io, ram_wr, tmr_wr, sts_rd;
    logic [1:0]           io_off;
    logic [RAM_ADDR_BITS-1:0] ram_idx;

    assign active  = !waiting_global;
    assign is_ram  = memory_addr < ADDR_SIZE'(RAM_DEPTH);
    assign is_io   = !is_ram && (memory_addr >= IO_BASE) && (memory_addr <= IO_LAST);
    assign io_off  = memory_addr[1:0] - IO_BASE[1:0];
    assign ram_idx = memory_addr[RAM_ADDR_BITS-1:0];
    assign ram_wr  = active && is_ram && memory_write_enable;
    assign tmr_wr  = active && is_io && (io_off == 2'd1) && memory_write_enable;
    assign sts_rd  = active && is_io && (io_off == 2'd2);

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [WORD_SIZE-1:0] cyc_q;

    always_ff @(posedge clock) begin
        if (reset) cyc_q <= '0;
        else       cyc_q <= cyc_q + ONE;
    end

    assign cyc_rd = cyc_q;
`else
    assign cyc_rd = '0;
`endif

    always_comb begin
        io_rd_d  = '0;
        led_d    = led_q;
        count_d  = count_q;
        done_d   = done_q;
        // A TIMER write landing on the final count suppresses the expiry.
        expire_d = (count_q == ONE) && !tmr_wr;
        if (active && is_io) begin
            case (io_off)
                2'd0:    io_rd_d = led_q;
                2'd1:    io_rd_d = count_q;
                2'd2:    io_rd_d = {{(WORD_SIZE-1){1'b0}}, done_q};
                default: io_rd_d = cyc_rd;
            endcase
            if (memory_write_enable && io_off == 2'd0) led_d = memory_in;
        end
        if (tmr_wr)                count_d = memory_in;
        else if (count_q != '0)    count_d = count_q - ONE;
        if (expire_d)              done_d = 1'b1;
        else if (sts_rd)           done_d = 1'b0;
    end

    // RAM kept free of reset so it maps onto block memory; write-first on a same-cycle write.
    always_ff @(posedge clock) begin
        if (ram_wr) ram_q[ram_idx] <= memory_in;
        if (active) ram_rd_q <= ram_wr ? memory_in : ram_q[ram_idx];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ram_q  <= 1'b0;
            io_rd_q   <= '0;
            led_q     <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            if (active) begin
                rd_ram_q <= is_ram;
                io_rd_q  <= io_rd_d;
            end
            led_q     <= led_d;
            count_q   <= count_d;
            done_q    <= done_d;
            expired_q <= expire_d;
            if (active && !is_ram && !is_io) fault_q <= 1'b1;
        end
    end

    assign memory_out    = rd_ram_q ? ram_rd_q : io_rd_q;
    assign led_out       = led_q;
    assign timer_expired = expired_q;
    assign access_fault  = fault_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder with a behavioural model checked every cycle.
// Honours DMEM_CYCLE_COUNTER_EN the same way the design does.
module tb_data_memory_responder;
    localparam logic [17:0] IO = 18'h3FF00;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [17:0] memory_addr = IO;
    logic        memory_write_enable = 1'b0;
    logic [17:0] memory_in = '0;
    logic        waiting_global = 1'b0;
    logic [17:0] memory_out, led_out;
    logic        timer_expired, access_fault;

    int checks = 0;
    int errors = 0;

    data_memory_responder dut (
        .clock(clock), .reset(reset), .memory_addr(memory_addr),
        .memory_write_enable(memory_write_enable), .memory_in(memory_in),
        .waiting_global(waiting_global), .memory_out(memory_out), .led_out(led_out),
        .timer_expired(timer_expired), .access_fault(access_fault)
    );

    always #5 clock = ~clock;

    // Model state
    logic [17:0] mem [4096];
    bit          known [4096];
    logic [17:0] m_out, m_led, m_count, m_cyc;
    bit          m_known, m_done, m_exp, m_fault, m_valid;

    task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: inputs applied at a negedge, returns at the next negedge (outputs settled).
    task automatic drive(input logic [17:0] a, input logic we, input logic [17:0] d,
                         input logic w, input logic r);
        memory_addr = a; memory_write_enable = we; memory_in = d;
        waiting_global = w; reset = r;
        @(negedge clock);
    endtask

    task automatic idle();
        drive(IO, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        m_valid = 0;
        for (int i = 0; i < 4096; i++) known[i] = 0;
        forever begin
            @(posedge clock);
            if (reset) begin
                m_out = 0; m_known = 1; m_led = 0; m_count = 0; m_done = 0;
                m_exp = 0; m_fault = 0; m_cyc = 0; m_valid = 1;
            end else begin
                bit act, twr, nexp;
                logic [17:0] a, cycval;
                act    = !waiting_global;
                a      = memory_addr;
                twr    = act && a == IO + 18'd1 && memory_write_enable;
                nexp   = (m_count == 18'd1) && !twr;
`ifdef DMEM_CYCLE_COUNTER_EN
                cycval = m_cyc;
`else
                cycval = 0;
`endif
                if (act) begin
                    if (a < 18'd4096) begin
                        if (memory_write_enable) begin
                            mem[a[11:0]] = memory_in; known[a[11:0]] = 1;
                        end
                        m_out = mem[a[11:0]]; m_known = known[a[11:0]];
                    end else if (a >= IO && a <= IO + 18'd3) begin
                        m_known = 1;
                        case (a - IO)
                            18'd0:   m_out = m_led;
                            18'd1:   m_out = m_count;
                            18'd2:   m_out = {17'b0, m_done};
                            default: m_out = cycval;
                        endcase
                        if (memory_write_enable && a == IO) m_led = memory_in;
                        if (a == IO + 18'd2) m_done = 0;
                    end else begin
                        m_out = 0; m_known = 1; m_fault = 1;
                    end
                end
                if (twr) m_count = memory_in;
                else if (m_count != 0) m_count = m_count - 18'd1;
                if (nexp) m_done = 1;
                m_exp = nexp;
                m_cyc = m_cyc + 18'd1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (m_valid) begin
                if (m_known) chk("model memory_out", memory_out, m_out);
                chk("model led_out", led_out, m_led);
                chk("model timer_expired", {17'b0, timer_expired}, {17'b0, m_exp});
                chk("model access_fault", {17'b0, access_fault}, {17'b0, m_fault});
            end
        end
    end

    initial begin
        @(negedge clock);
        drive(IO, 1'b0, '0, 1'b0, 1'b1);
        drive(IO, 1'b0, '0, 1'b0, 1'b1);
        chk("reset memory_out", memory_out, 18'h0);
        chk("reset led_out", led_out, 18'h0);
        chk("reset timer_expired", {17'b0, timer_expired}, 18'h0);
        chk("reset access_fault", {17'b0, access_fault}, 18'h0);

        // RAM write then read, and same-cycle write/read
        drive(18'd5, 1'b1, 18'h155, 1'b0, 1'b0);
        drive(18'd5, 1'b0, '0, 1'b0, 1'b0);
        chk("ram read after write", memory_out, 18'h155);
        drive(18'd9, 1'b1, 18'h2AA, 1'b0, 1'b0);
        chk("ram write-first", memory_out, 18'h2AA);

        // Timer count 3 read back as 3,2,1,0 with one pulse on the 3rd edge after the write
        drive(IO + 18'd1, 1'b1, 18'd3, 1'b0, 1'b0);
        chk("timer pulse w", {17'b0, timer_expired}, 18'h0);
        for (int i = 1; i <= 4; i++) begin
            drive(IO + 18'd1, 1'b0, '0, 1'b0, 1'b0);
            chk("timer count read", memory_out, 18'(4 - i));
            chk("timer pulse", {17'b0, timer_expired}, (i == 3) ? 18'h1 : 18'h0);
        end
        drive(IO + 18'd2, 1'b0, '0, 1'b0, 1'b0);
        chk("status after expiry", memory_out, 18'h1);
        drive(IO + 18'd2, 1'b0, '0, 1'b0, 1'b0);
        chk("status cleared", memory_out, 18'h0);

        // Timer write on the would-expire cycle wins; writing 0 stops it
        drive(IO + 18'd1, 1'b1, 18'd2, 1'b0, 1'b0);
        idle();
        drive(IO + 18'd1, 1'b1, 18'd5, 1'b0, 1'b0);
        chk("write beats expiry", {17'b0, timer_expired}, 18'h0);
        drive(IO + 18'd1, 1'b1, 18'd0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) idle();
        drive(IO + 18'd2, 1'b0, '0, 1'b0, 1'b0);
        chk("no done after overwrite", memory_out, 18'h0);

        // Status read on the expiry cycle returns 0 and done stays set
        drive(IO + 18'd1, 1'b1, 18'd1, 1'b0, 1'b0);
        drive(IO + 18'd2, 1'b0, '0, 1'b0, 1'b0);
        chk("status on expiry", memory_out, 18'h0);
        chk("pulse with status read", {17'b0, timer_expired}, 18'h1);
        drive(IO + 18'd2, 1'b0, '0, 1'b0, 1'b0);
        chk("done kept set", memory_out, 18'h1);

        // LED write then freeze
        drive(IO, 1'b1, 18'h3FFFF, 1'b0, 1'b0);
        chk("led write", led_out, 18'h3FFFF);
        drive(18'd5, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive((i == 1) ? IO : 18'd9, (i == 1), 18'h00123, 1'b1, 1'b0);
            chk("freeze memory_out", memory_out, 18'h155);
            chk("freeze led_out", led_out, 18'h3FFFF);
        end
        drive(18'h20000, 1'b0, '0, 1'b1, 1'b0);
        chk("frozen unmapped no fault", {17'b0, access_fault}, 18'h0);

        // Unmapped access
        drive(18'h20000, 1'b0, '0, 1'b0, 1'b0);
        chk("unmapped read", memory_out, 18'h0);
        chk("fault set", {17'b0, access_fault}, 18'h1);
        for (int i = 0; i < 100; i++) idle();
        chk("fault sticky", {17'b0, access_fault}, 18'h1);
        drive(IO, 1'b0, '0, 1'b0, 1'b1);
        chk("fault cleared by reset", {17'b0, access_fault}, 18'h0);
        drive(IO + 18'd3, 1'b0, '0, 1'b0, 1'b0);
        chk("cycles mapped", {17'b0, access_fault}, 18'h0);

        // Reset mid-count
        drive(IO + 18'd1, 1'b1, 18'd10, 1'b0, 1'b0);
        idle(); idle(); idle();
        drive(IO, 1'b0, '0, 1'b0, 1'b1);
        drive(IO + 18'd1, 1'b0, '0, 1'b0, 1'b0);
        chk("count after reset", memory_out, 18'h0);
        drive(IO + 18'd3, 1'b0, '0, 1'b0, 1'b0);
`ifdef DMEM_CYCLE_COUNTER_EN
        chk("cycle counter", memory_out, 18'h1);
`else
        chk("cycle counter absent", memory_out, 18'h0);
`endif
        for (int i = 0; i < 12; i++) begin
            idle();
            chk("no pulse after reset", {17'b0, timer_expired}, 18'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
